// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - MM:SS BCD stopwatch core with synchronized slow-clock tick detection
//
// Purpose:
//   Turns the asynchronous 1 Hz / 2 Hz divided clocks and the pause button into
//   single-cycle ticks in the master_clk domain. It runs a BCD MM:SS counter with
//   RUN / PAUSED / ADJUST behaviour.
//
// Ports:
//   master_clk         system clock
//   rst                asynchronous active-low reset
//   one_hz_clk         1 Hz divided clock, sampled as data
//   two_hz_clk         2 Hz divided clock, sampled as data
//   pause_btn          debounced level, each rising edge toggles paused
//   adj                1 = adjust mode
//   sel                adjust target, 0 = minutes, 1 = seconds
//   min_tens/min_ones  minutes BCD digits
//   sec_tens/sec_ones  seconds BCD digits
//   paused             paused flag
//   blink              blink phase, toggles per 2 Hz tick while adjusting
module stopwatch_core #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MIN     = 99
) (
    input  logic       master_clk,
    input  logic       rst,
    input  logic       one_hz_clk,
    input  logic       two_hz_clk,
    input  logic       pause_btn,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused,
    output logic       blink
);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("stopwatch_core: SYNC_STAGES must be at least 2");
    end
    if (MAX_MIN < 1 || MAX_MIN > 99) begin : g_bad_max_min
        $error("stopwatch_core: MAX_MIN must be in 1..99");
    end

    localparam int         N_IN   = 5;
    localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MO = 4'(MAX_MIN % 10);

    // Bit order: {sel, adj, pause_btn, two_hz_clk, one_hz_clk}
    logic [N_IN-1:0]        async_in;
    logic [N_IN-1:0]        sync_q [SYNC_STAGES];
    logic [N_IN-1:0]        synced;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   sync_valid;
    logic [2:0]             hist_q;
    logic [2:0]             armed_q;
    logic [2:0]             armed_d;
    logic [2:0]             tick;
    logic                   one_tick;
    logic                   two_tick;
    logic                   pause_tick;
    logic                   adj_s;
    logic                   sel_s;

    logic [3:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    logic [3:0] min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
    logic       paused_q, paused_d;
    logic       blink_q, blink_d;

    assign async_in = {sel, adj, pause_btn, two_hz_clk, one_hz_clk};
    assign synced   = sync_q[SYNC_STAGES-1];
    assign adj_s    = synced[3];
    assign sel_s    = synced[4];

    // The synchronizer flops reset to 0. That is not a real sample of the input.
    // fill_q marks when the last stage holds real data. Without it, an input held
    // high through reset would look like a 0->1 edge.
    assign sync_valid = fill_q[SYNC_STAGES-1];

    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            fill_q  <= '0;
            hist_q  <= '0;
            armed_q <= '0;
        end else begin
            sync_q[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            hist_q  <= synced[2:0];
            armed_q <= armed_d;
        end
    end

    // A detector arms once it has seen a genuine low level.
    assign armed_d    = armed_q | ({3{sync_valid}} & ~synced[2:0]);
    assign tick       = synced[2:0] & ~hist_q & armed_q;
    assign one_tick   = tick[0];
    assign two_tick   = tick[1];
    assign pause_tick = tick[2];

    // Returns {carry, tens, ones}. The seconds pair wraps at 59.
    function automatic logic [8:0] inc_sec(input logic [3:0] t, input logic [3:0] o);
        logic [8:0] r;
        if (o == 4'd9) begin
            if (t == 4'd5) r = {1'b1, 4'd0, 4'd0};
            else           r = {1'b0, t + 4'd1, 4'd0};
        end else begin
            r = {1'b0, t, o + 4'd1};
        end
        return r;
    endfunction

    // Returns {tens, ones}. The minutes pair wraps at MAX_MIN.
    function automatic logic [7:0] inc_min(input logic [3:0] t, input logic [3:0] o);
        logic [7:0] r;
        if (t == MAX_MT && o == MAX_MO) r = 8'h00;
        else if (o == 4'd9)             r = {t + 4'd1, 4'd0};
        else                            r = {t, o + 4'd1};
        return r;
    endfunction

    always_comb begin
        logic [8:0] s_inc;
        logic [7:0] m_inc;
        logic       run_mode;

        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        blink_d    = 1'b0;
        s_inc      = inc_sec(sec_tens_q, sec_ones_q);
        m_inc      = inc_min(min_tens_q, min_ones_q);

        // The mode uses the pre-toggle paused value. A pause tick that coincides
        // with a one-second tick still lets that second count.
        run_mode = !adj_s && !paused_q;
        paused_d = paused_q ^ pause_tick;

        if (run_mode && one_tick) begin
            {sec_tens_d, sec_ones_d} = s_inc[7:0];
            if (s_inc[8]) begin
                {min_tens_d, min_ones_d} = m_inc;
            end
        end

        if (adj_s) begin
            blink_d = blink_q ^ two_tick;
            if (two_tick) begin
                if (sel_s) {sec_tens_d, sec_ones_d} = s_inc[7:0];
                else       {min_tens_d, min_ones_d} = m_inc;
            end
        end
    end

    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            min_tens_q <= '0;
            min_ones_q <= '0;
            sec_tens_q <= '0;
            sec_ones_q <= '0;
            paused_q   <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            paused_q   <= paused_d;
            blink_q    <= blink_d;
        end
    end

    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign paused   = paused_q;
    assign blink    = blink_q;

endmodule
